// File: rtl/mapper_bpsk_wifi.sv
// ---------------------------------------------------------------------------
// mapper_bpsk_wifi
//   WiFi TX-side BPSK mapper. Serial coded bits are mapped onto 12-bit signed
//   I/Q constellation points (bit 1 -> +AMP, bit 0 -> -AMP, Q = 0) for the
//   IFFT subcarrier loader. A two-entry skid buffer (head + skid register)
//   provides a full valid/ready handshake on both sides. A subcarrier counter
//   flags the last point of each OFDM symbol and a symbol counter tallies
//   completed symbols.
//
// Ports
//   clk            in   1      system clock, rising edge
//   reset          in   1      asynchronous active-high reset
//   clear          in   1      synchronous flush: empties buffer, zeroes counters
//   valid_in       in   1      data_in valid
//   data_in        in   1      coded bit to map
//   ready_out      out  1      mapper can accept a bit this cycle
//   valid_out      out  1      data_out_real/imag valid
//   ready_in       in   1      downstream accepts output this cycle
//   data_out_real  out  WIDTH  I component, +AMP or -AMP (0 when empty)
//   data_out_imag  out  WIDTH  Q component, always 0
//   last_out       out  1      current point is subcarrier N_SC-1
//   sym_cnt        out  SYM_W  completed symbols, wraps at 2^SYM_W
// ---------------------------------------------------------------------------
module mapper_bpsk_wifi #(
    parameter int WIDTH = 12,
    parameter int AMP   = 1024,
    parameter int N_SC  = 48,
    parameter int SYM_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             valid_in,
    input  logic             data_in,
    output logic             ready_out,
    output logic             valid_out,
    input  logic             ready_in,
    output logic [WIDTH-1:0] data_out_real,
    output logic [WIDTH-1:0] data_out_imag,
    output logic             last_out,
    output logic [SYM_W-1:0] sym_cnt
);

    localparam int SC_W = (N_SC > 1) ? $clog2(N_SC) : 1;
    localparam logic [SC_W-1:0]  SC_LAST = SC_W'(N_SC - 1);
    localparam logic [SC_W-1:0]  SC_ONE  = SC_W'(1);
    localparam logic [SYM_W-1:0] SYM_ONE = SYM_W'(1);
    localparam logic [WIDTH-1:0] AMP_P   = WIDTH'(AMP);
    localparam logic [WIDTH-1:0] NEG_P   = ~AMP_P + {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_t;

    occ_t             state_r;
    occ_t             state_nxt;
    logic             head_load;
    logic             head_from_skid;
    logic             skid_load;
    logic             skid_bit_r;
    logic [WIDTH-1:0] real_r;
    logic [SC_W-1:0]  sc_cnt_r;
    logic [SYM_W-1:0] sym_cnt_r;
    logic             in_xfer;
    logic             out_xfer;

    // BPSK constellation: 1 -> +AMP, 0 -> -AMP (two's complement)
    function automatic logic [WIDTH-1:0] map_bit(input logic b);
        logic [WIDTH-1:0] r;
        if (b) begin
            r = AMP_P;
        end else begin
            r = NEG_P;
        end
        return r;
    endfunction

    assign ready_out     = (state_r != FULL);
    assign valid_out     = (state_r != EMPTY);
    assign in_xfer       = valid_in & ready_out;
    assign out_xfer      = valid_out & ready_in;
    assign data_out_real = real_r;
    assign data_out_imag = {WIDTH{1'b0}};
    assign last_out      = valid_out & (sc_cnt_r == SC_LAST);
    assign sym_cnt       = sym_cnt_r;

    // Occupancy state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= EMPTY;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Next occupancy and buffer load strobes; clear wins over any transfer
    always_comb begin
        state_nxt      = state_r;
        head_load      = 1'b0;
        head_from_skid = 1'b0;
        skid_load      = 1'b0;
        case (state_r)
            EMPTY: begin
                if (in_xfer) begin
                    state_nxt = ONE;
                    head_load = 1'b1;
                end else begin
                    state_nxt = EMPTY;
                end
            end
            ONE: begin
                if (in_xfer && out_xfer) begin
                    state_nxt = ONE;
                    head_load = 1'b1;
                end else if (in_xfer) begin
                    state_nxt = FULL;
                    skid_load = 1'b1;
                end else if (out_xfer) begin
                    state_nxt = EMPTY;
                end else begin
                    state_nxt = ONE;
                end
            end
            FULL: begin
                if (out_xfer) begin
                    state_nxt      = ONE;
                    head_from_skid = 1'b1;
                end else begin
                    state_nxt = FULL;
                end
            end
            default: begin
                state_nxt = EMPTY;
            end
        endcase
        if (clear) begin
            state_nxt      = EMPTY;
            head_load      = 1'b0;
            head_from_skid = 1'b0;
            skid_load      = 1'b0;
        end else begin
            state_nxt = state_nxt;
        end
    end

    // Head register holds the mapped point; zeroed whenever the buffer empties
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            real_r <= {WIDTH{1'b0}};
        end else if (clear) begin
            real_r <= {WIDTH{1'b0}};
        end else if (head_load) begin
            real_r <= map_bit(data_in);
        end else if (head_from_skid) begin
            real_r <= map_bit(skid_bit_r);
        end else if (state_nxt == EMPTY) begin
            real_r <= {WIDTH{1'b0}};
        end else begin
            real_r <= real_r;
        end
    end

    // Skid register catches the bit accepted while the head is stalled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            skid_bit_r <= 1'b0;
        end else if (clear) begin
            skid_bit_r <= 1'b0;
        end else if (skid_load) begin
            skid_bit_r <= data_in;
        end else begin
            skid_bit_r <= skid_bit_r;
        end
    end

    // Subcarrier and symbol counters advance only on output transfers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sc_cnt_r  <= {SC_W{1'b0}};
            sym_cnt_r <= {SYM_W{1'b0}};
        end else if (clear) begin
            sc_cnt_r  <= {SC_W{1'b0}};
            sym_cnt_r <= {SYM_W{1'b0}};
        end else if (out_xfer) begin
            if (sc_cnt_r == SC_LAST) begin
                sc_cnt_r  <= {SC_W{1'b0}};
                sym_cnt_r <= sym_cnt_r + SYM_ONE;
            end else begin
                sc_cnt_r  <= sc_cnt_r + SC_ONE;
                sym_cnt_r <= sym_cnt_r;
            end
        end else begin
            sc_cnt_r  <= sc_cnt_r;
            sym_cnt_r <= sym_cnt_r;
        end
    end

endmodule
